// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple add/subtract unit.
// Provides the chunk-width helper, the add/sub mode encoding and a
// result record {sum, cout, ovf} sized for the widest supported operand.
package adder_pkg;

    // Widest operand a result record can carry.
    localparam int MAX_WIDTH = 64;

    // Mode encoding for the 'sub' input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] sum;
        logic                 cout;
        logic                 ovf;
    } result_t;

    // Bits handled by each pipeline stage. A zero stage count falls back to
    // a single full-width chunk so elaboration reaches the legality check
    // instead of dividing by zero.
    function automatic int chunk_width(input int width, input int stages);
        if (stages <= 0) begin
            return width;
        end
        return width / stages;
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell, the building block of every ripple chunk.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: a, b, ci in; s (sum), co (carry-out) out.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_chunk.sv
// W-bit ripple-carry adder slice built from a chain of fulladder cells.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: a, b, cin in; s, cout, c_msb_in (carry into bit W-1, for overflow) out.
module ripple_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    // c[i] is the carry into bit i; c[W] leaves the slice.
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fulladder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout     = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple add/subtract: WIDTH bits split into STAGES chunks, one chunk per clock.
// Latency: STAGES cycles from accept to out_valid; throughput one beat per cycle.
// Backpressure: global stall when out_valid && !out_ready; in_ready follows out_ready combinationally.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, a, b, cin, sub in;
//        out_valid/out_ready, sum, cout (sub mode: 1 = no borrow), ovf (signed overflow) out.
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_ripple_adder: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    // Every register in the pipe moves together; a held output freezes all of it.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction is a + ~b + ~borrow, so invert once at the entry.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    assign b_eff   = (sub == MODE_SUB) ? ~b   : b;
    assign cin_eff = (sub == MODE_SUB) ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be summed at this stage (chunk k and above).
        localparam int IN_W = WIDTH - k * CHUNK;
        // Completed sum bits leaving this stage (chunks 0..k).
        localparam int LO_W = (k + 1) * CHUNK;

        logic [IN_W-1:0]  op_a;
        logic [IN_W-1:0]  op_b;
        logic             c_in;
        logic             v_in;
        logic [CHUNK-1:0] chunk_s;
        logic             chunk_c;
        logic             chunk_m;

        logic [LO_W-1:0]  s_d, s_q;
        logic             c_d, c_q;
        logic             v_d, v_q;

        if (k == 0) begin : g_first
            assign op_a = a;
            assign op_b = b_eff;
            assign c_in = cin_eff;
            assign v_in = in_valid;
        end else begin : g_next
            assign op_a = g_stage[k-1].g_skew.a_q;
            assign op_b = g_stage[k-1].g_skew.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        ripple_chunk #(
            .W (CHUNK)
        ) u_chunk (
            .a        (op_a[CHUNK-1:0]),
            .b        (op_b[CHUNK-1:0]),
            .cin      (c_in),
            .s        (chunk_s),
            .cout     (chunk_c),
            .c_msb_in (chunk_m)
        );

        // De-skew: append this chunk above the lower chunks already finished.
        if (k == 0) begin : g_sum_first
            always_comb begin
                s_d = chunk_s;
            end
        end else begin : g_sum_next
            always_comb begin
                s_d = {chunk_s, g_stage[k-1].s_q};
            end
        end

        always_comb begin
            c_d = chunk_c;
            v_d = v_in;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_d;
            end
        end

        // Skew: carry the not-yet-summed upper operand chunks to the next stage.
        if (k < STAGES - 1) begin : g_skew
            logic [IN_W-CHUNK-1:0] a_d, a_q;
            logic [IN_W-CHUNK-1:0] b_d, b_q;

            always_comb begin
                a_d = op_a[IN_W-1:CHUNK];
                b_d = op_b[IN_W-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // Only the top chunk sees the MSB, so only it can form signed overflow.
        if (k == STAGES - 1) begin : g_last
            logic ovf_d, ovf_q;

            always_comb begin
                ovf_d = chunk_c ^ chunk_m;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end else begin : g_mid
            logic unused_c_msb;
            assign unused_c_msb = chunk_m;
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: a 16/4 instance for directed,
// streaming, stall and reset cases, plus 4/2, 4/1 and 4/4 instances fed the
// exhaustive 4-bit operand space followed by random beats.
module tb_pipelined_ripple_adder;
    import adder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact-width sum, overflow from operand/result sign bits.
    function automatic result_t model(input logic [63:0] a, input logic [63:0] b,
                                      input logic cin, input logic sub, input int w);
        logic [64:0] mask, ae, be, full;
        result_t r;
        mask   = (65'd1 << w) - 65'd1;
        ae     = {1'b0, a} & mask;
        be     = {1'b0, (sub ? ~b : b)} & mask;
        full   = ae + be + {64'd0, (cin ^ sub)};
        r.sum  = full[63:0] & mask[63:0];
        r.cout = full[w];
        r.ovf  = (ae[w-1] == be[w-1]) && (r.sum[w-1] != ae[w-1]);
        return r;
    endfunction

    // ---------------- main 16-bit, 4-stage instance ----------------
    logic        m_in_valid = 1'b0, m_in_ready, m_out_valid, m_out_ready = 1'b1;
    logic [15:0] m_a = '0, m_b = '0, m_sum;
    logic        m_cin = 1'b0, m_sub = 1'b0, m_cout, m_ovf;

    pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) u_w16s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .sum(m_sum), .cout(m_cout), .ovf(m_ovf));

    function automatic result_t main_res();
        result_t r;
        r      = '0;
        r.sum  = 64'(m_sum);
        r.cout = m_cout;
        r.ovf  = m_ovf;
        return r;
    endfunction

    result_t m_sb[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_in_valid && m_in_ready)
                m_sb.push_back(model(64'(m_a), 64'(m_b), m_cin, m_sub, 16));
            if (m_out_valid && m_out_ready) begin
                if (m_sb.size() == 0) check_eq("w16s4_ghost", 66'(m_out_valid), 66'(0));
                else check_eq("w16s4_order", main_res(), m_sb.pop_front());
            end
        end
    end

    // ---------------- small 4-bit instances ----------------
    logic       s_in_valid = 1'b0, s_out_ready = 1'b1;
    logic [3:0] s_a = '0, s_b = '0;
    logic       s_cin = 1'b0, s_sub = 1'b0;

    logic       r2_in_ready, r2_out_valid, r2_cout, r2_ovf;
    logic       r1_in_ready, r1_out_valid, r1_cout, r1_ovf;
    logic       r4_in_ready, r4_out_valid, r4_cout, r4_ovf;
    logic [3:0] r2_sum, r1_sum, r4_sum;

    pipelined_ripple_adder #(.WIDTH(4), .STAGES(2)) u_w4s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(r2_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(r2_out_valid),
        .out_ready(s_out_ready), .sum(r2_sum), .cout(r2_cout), .ovf(r2_ovf));
    pipelined_ripple_adder #(.WIDTH(4), .STAGES(1)) u_w4s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(r1_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(r1_out_valid),
        .out_ready(s_out_ready), .sum(r1_sum), .cout(r1_cout), .ovf(r1_ovf));
    pipelined_ripple_adder #(.WIDTH(4), .STAGES(4)) u_w4s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(r4_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(r4_out_valid),
        .out_ready(s_out_ready), .sum(r4_sum), .cout(r4_cout), .ovf(r4_ovf));

    function automatic result_t small_res(input logic [3:0] s, input logic c, input logic o);
        result_t r;
        r      = '0;
        r.sum  = 64'(s);
        r.cout = c;
        r.ovf  = o;
        return r;
    endfunction

    result_t q2[$], q1[$], q4[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_in_valid && r2_in_ready) q2.push_back(model(64'(s_a), 64'(s_b), s_cin, s_sub, 4));
            if (s_in_valid && r1_in_ready) q1.push_back(model(64'(s_a), 64'(s_b), s_cin, s_sub, 4));
            if (s_in_valid && r4_in_ready) q4.push_back(model(64'(s_a), 64'(s_b), s_cin, s_sub, 4));
            if (r2_out_valid && s_out_ready) begin
                if (q2.size() == 0) check_eq("w4s2_ghost", 66'(r2_out_valid), 66'(0));
                else check_eq("w4s2", small_res(r2_sum, r2_cout, r2_ovf), q2.pop_front());
            end
            if (r1_out_valid && s_out_ready) begin
                if (q1.size() == 0) check_eq("w4s1_ghost", 66'(r1_out_valid), 66'(0));
                else check_eq("w4s1", small_res(r1_sum, r1_cout, r1_ovf), q1.pop_front());
            end
            if (r4_out_valid && s_out_ready) begin
                if (q4.size() == 0) check_eq("w4s4_ghost", 66'(r4_out_valid), 66'(0));
                else check_eq("w4s4", small_res(r4_sum, r4_cout, r4_ovf), q4.pop_front());
            end
        end
    end

    // ---------------- directed vectors (hand-computed) ----------------
    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] sum;
        logic        cout, ovf;
    } vec_t;

    vec_t vecs[8];

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        bit acc = 1'b0;
        m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = m_in_ready;
            @(posedge clk); #1;
        end
        if (!acc) check_eq("send_timeout", 66'(m_in_ready), 66'(1));
        m_in_valid = 1'b0;
    endtask

    task automatic run_single(input vec_t v, input string tag);
        result_t e;
        e = '0; e.sum = 64'(v.sum); e.cout = v.cout; e.ovf = v.ovf;
        m_a = v.a; m_b = v.b; m_cin = v.cin; m_sub = v.sub; m_in_valid = 1'b1;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 66'(m_in_ready), 66'(1));
        @(posedge clk); #1;                     // accept edge T
        m_in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_early_vld"}, 66'(m_out_valid), 66'(0));
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            check_eq({tag, "_early_vld"}, 66'(m_out_valid), 66'(0));
        end
        @(posedge clk); @(negedge clk);         // after edge T+3
        check_eq({tag, "_vld"}, 66'(m_out_valid), 66'(1));
        check_eq({tag, "_res"}, main_res(), e);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};

        // Reset state.
        #3 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check_eq("rst_out_valid", 66'(m_out_valid), 66'(0));
        check_eq("rst_result", main_res(), result_t'(0));
        check_eq("rst_in_ready", 66'(m_in_ready), 66'(1));
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed add/sub with latency checks.
        for (int i = 0; i < 8; i++) run_single(vecs[i], $sformatf("vec%0d", i));

        // Streaming: 8 back-to-back beats, 8 results on consecutive cycles.
        begin
            logic [15:0] sa[8], sb_[8];
            logic        sc[8], ss[8];
            result_t     se[8];
            for (int i = 0; i < 8; i++) begin
                sa[i] = 16'($urandom); sb_[i] = 16'($urandom);
                sc[i] = 1'($urandom);  ss[i] = 1'($urandom);
                se[i] = model(64'(sa[i]), 64'(sb_[i]), sc[i], ss[i], 16);
            end
            m_a = sa[0]; m_b = sb_[0]; m_cin = sc[0]; m_sub = ss[0]; m_in_valid = 1'b1;
            for (int t = 0; t < 12; t++) begin
                @(posedge clk); #1;
                if (t + 1 < 8) begin
                    m_a = sa[t+1]; m_b = sb_[t+1]; m_cin = sc[t+1]; m_sub = ss[t+1];
                end else begin
                    m_in_valid = 1'b0;
                end
                @(negedge clk);
                if (t >= 3 && t <= 10) begin
                    check_eq("stream_vld", 66'(m_out_valid), 66'(1));
                    check_eq("stream_res", main_res(), se[t-3]);
                end else begin
                    check_eq("stream_idle", 66'(m_out_valid), 66'(0));
                end
            end
            @(posedge clk); #1;
        end

        // Backpressure: fill with out_ready=0, hold 3 cycles, then resume.
        m_out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, 1'b0);
        send(16'hF000, 16'h1000, 1'b0, 1'b0);
        send(16'h0010, 16'h0020, 1'b1, 1'b1);
        send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        m_a = 16'hAAAA; m_b = 16'h5555; m_cin = 1'b1; m_sub = 1'b0; m_in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_in_ready", 66'(m_in_ready), 66'(0));
            check_eq("bp_out_valid", 66'(m_out_valid), 66'(1));
            check_eq("bp_frozen", main_res(), model(64'h0101, 64'h0202, 1'b0, 1'b0, 16));
            @(posedge clk); #1;
        end
        m_out_ready = 1'b1;
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        send(16'h0003, 16'h0009, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_eq("bp_drain", 66'(m_sb.size()), 66'(0));

        // Mid-stream reset with three beats in flight.
        m_out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h2222, 16'h0001, 1'b0, 1'b1);
        send(16'h4000, 16'h4000, 1'b0, 1'b0);
        @(posedge clk); #2;
        check_eq("mid_rst_setup", 66'(m_out_valid), 66'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 66'(m_out_valid), 66'(0));
        check_eq("mid_rst_result", main_res(), result_t'(0));
        check_eq("mid_rst_in_ready", 66'(m_in_ready), 66'(1));
        m_sb.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        m_out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_eq("mid_rst_no_ghost", 66'(m_out_valid), 66'(0));
        end
        @(posedge clk); #1;
        run_single(vecs[4], "post_rst");

        // Small configs: exhaustive operand space, then 200 random beats.
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    for (int is = 0; is < 2; is++) begin
                        s_a = 4'(ia); s_b = 4'(ib); s_cin = 1'(ic); s_sub = 1'(is);
                        s_in_valid = 1'b1;
                        @(posedge clk); #1;
                    end
        for (int i = 0; i < 200; i++) begin
            s_a = 4'($urandom); s_b = 4'($urandom); s_cin = 1'($urandom); s_sub = 1'($urandom);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("w4s2_drain", 66'(q2.size()), 66'(0));
        check_eq("w4s1_drain", 66'(q1.size()), 66'(0));
        check_eq("w4s4_drain", 66'(q4.size()), 66'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
